hamming_seq: RTL and testbench



---
 rtl/hamming_pkg.sv | 31 +++
 rtl/hamming_popcnt.sv | 25 ++
 rtl/hamming_seq.sv | 156 +++++++++++++++
 tb/tb_hamming_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// hamming_pkg
// Shared definitions for the sequential Hamming distance / similarity counter.
//   state_t        : controller states (IDLE, RUN, DONE)
//   MODE_DIST/SIM  : values of the per-transaction mode input
//   popcount()     : generic population count over a zero-extended vector,
//                    used by hamming_popcnt for any chunk size up to
//                    POPCNT_MAX_W bits
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_DIST = 1'b0;
    localparam logic MODE_SIM  = 1'b1;

    localparam int POPCNT_MAX_W = 256;

    // Callers zero-extend narrower vectors; constant zero bits fold away.
    function automatic int unsigned popcount(input logic [POPCNT_MAX_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < POPCNT_MAX_W; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/hamming_popcnt.sv
// hamming_popcnt
// Combinational population count of one CHUNK-bit slice.
// Ports:
//   bits  [CHUNK]              : slice to count
//   count [$clog2(CHUNK+1)]    : number of ones in bits
module hamming_popcnt
    import hamming_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0]               bits,
    output logic [$clog2(CHUNK+1)-1:0]     count
);

    localparam int OW = $clog2(CHUNK+1);

    generate
        if (CHUNK < 1 || CHUNK > POPCNT_MAX_W) begin : g_bad_chunk
            $error("hamming_popcnt: CHUNK out of supported range");
        end
    endgenerate

    assign count = OW'(popcount(POPCNT_MAX_W'(bits)));

endmodule

// File: rtl/hamming_seq.sv
// hamming_seq
// Sequential Hamming distance / similarity counter. Accepts one operand pair
// over a valid/ready handshake, counts CHUNK bits per clock and presents the
// count over a second valid/ready handshake. One transaction in flight.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready high only in IDLE)
//   a, b [WIDTH]          : operands, sampled at the accept edge
//   mode                  : 0 = distance (ones of a^b), 1 = similarity
//   out_valid / out_ready : result handshake (out_valid high only in DONE)
//   result [DW]           : unsigned count, held while out_valid is high
// Optional feature (macro HAMMING_SEQ_THRESH_EN):
//   thresh [DW]           : sampled with the operands
//   below_thresh          : (count < thresh), valid under out_valid
module hamming_seq
    import hamming_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int CHUNK = 8,
    localparam int DW    = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mode,
`ifdef HAMMING_SEQ_THRESH_EN
    input  logic [DW-1:0]    thresh,
    output logic             below_thresh,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    result
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = $clog2(CHUNK+1);

    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("hamming_seq: WIDTH must be at least 1");
        end
        if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
            $error("hamming_seq: CHUNK must divide WIDTH exactly");
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   vec_reg;
    logic [DW-1:0]      acc_reg;
    logic [IW-1:0]      idx_reg;
    logic [DW-1:0]      result_reg;
    logic [CHUNK-1:0]   chunk_sel;
    logic [PW-1:0]      chunk_cnt;
    logic [DW-1:0]      acc_sum;
    logic               last_chunk;
    logic               accept;

    // Slice the captured vector into chunks; idx selects the one counted now.
    logic [CHUNK-1:0] chunks [NCH];
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chunks
            assign chunks[gi] = vec_reg[gi*CHUNK +: CHUNK];
        end
        if (NCH == 1) begin : g_sel_single
            assign chunk_sel = chunks[0];
        end else begin : g_sel_multi
            assign chunk_sel = chunks[idx_reg];
        end
    endgenerate

    hamming_popcnt #(.CHUNK(CHUNK)) u_popcnt (
        .bits  (chunk_sel),
        .count (chunk_cnt)
    );

    assign acc_sum    = acc_reg + DW'(chunk_cnt);
    assign last_chunk = (idx_reg == IW'(NCH-1));
    assign accept     = (state_reg == IDLE) && in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Handshake outputs decode the registered state only, so neither
    // in_valid nor out_ready has a combinational path to an output.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                if (last_chunk) state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_reg    <= '0;
            acc_reg    <= '0;
            idx_reg    <= '0;
            result_reg <= '0;
        end else if (accept) begin
            vec_reg <= (mode == MODE_SIM) ? ~(a ^ b) : (a ^ b);
            acc_reg <= '0;
            idx_reg <= '0;
        end else if (state_reg == RUN) begin
            acc_reg <= acc_sum;
            if (last_chunk) begin
                // Leave idx at 0 rather than stepping past the last chunk.
                idx_reg    <= '0;
                result_reg <= acc_sum;
            end else begin
                idx_reg <= idx_reg + 1'b1;
            end
        end
    end

    assign result = result_reg;

`ifdef HAMMING_SEQ_THRESH_EN
    logic [DW-1:0] thresh_reg;
    logic          below_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thresh_reg <= '0;
            below_reg  <= 1'b0;
        end else if (accept) begin
            thresh_reg <= thresh;
        end else if (state_reg == RUN && last_chunk) begin
            below_reg <= (acc_sum < thresh_reg);
        end
    end

    assign below_thresh = below_reg;
`endif

endmodule

// File: tb/tb_hamming_seq.sv
module tb_hamming_seq;

    localparam int W1 = 32;
    localparam int C1 = 8;
    localparam int N1 = W1 / C1;
    localparam int D1 = $clog2(W1+1);
    localparam int W2 = 4;
    localparam int D2 = $clog2(W2+1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 32-bit instance
    logic          in_valid = 1'b0, in_ready, mode = 1'b0;
    logic [W1-1:0] a = '0, b = '0;
    logic          out_valid, out_ready = 1'b1;
    logic [D1-1:0] result;
    // 4-bit instance (legacy-compatible configuration)
    logic          in_valid4 = 1'b0, in_ready4, mode4 = 1'b0;
    logic [W2-1:0] a4 = '0, b4 = '0;
    logic          out_valid4, out_ready4 = 1'b1;
    logic [D2-1:0] result4;
`ifdef HAMMING_SEQ_THRESH_EN
    logic [D1-1:0] thresh = '0;
    logic          below_thresh;
    logic [D2-1:0] thresh4 = '0;
    logic          below_thresh4;
`endif

    hamming_seq #(.WIDTH(W1), .CHUNK(C1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode),
`ifdef HAMMING_SEQ_THRESH_EN
        .thresh(thresh), .below_thresh(below_thresh),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    hamming_seq #(.WIDTH(W2), .CHUNK(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .mode(mode4),
`ifdef HAMMING_SEQ_THRESH_EN
        .thresh(thresh4), .below_thresh(below_thresh4),
`endif
        .out_valid(out_valid4), .out_ready(out_ready4), .result(result4)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the bits, count differing (mode 0) or equal (mode 1).
    function automatic int ref_count(input logic [31:0] x, input logic [31:0] y,
                                     input bit m, input int w);
        int n = 0;
        for (int i = 0; i < w; i++) begin
            if ((x[i] == y[i]) == m) n++;
        end
        return n;
    endfunction

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        bit          mode;
        int          exp;
    } vec_t;

    // One full transaction on the 32-bit instance with out_ready held high.
    task automatic run32(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                         input bit tm, input int exp, input int thr, input int thr_after);
        int lat;
        @(negedge clk);
        a = ta; b = tb_; mode = tm; in_valid = 1'b1;
`ifdef HAMMING_SEQ_THRESH_EN
        thresh = D1'(thr);
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~ta; b = '0; mode = ~tm;          // operands must already be captured
`ifdef HAMMING_SEQ_THRESH_EN
        thresh = D1'(thr_after);
`endif
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, lat, N1);
        check({name, " result"}, int'(result), exp);
`ifdef HAMMING_SEQ_THRESH_EN
        check({name, " below_thresh"}, int'(below_thresh), (exp < thr) ? 1 : 0);
`endif
        @(posedge clk); #1;
        check({name, " back to idle"}, {30'd0, in_ready, out_valid}, 2);
    endtask

    task automatic run4(input string name, input logic [3:0] ta, input logic [3:0] tb_,
                        input bit tm, input int exp);
        int lat;
        @(negedge clk);
        a4 = ta; b4 = tb_; mode4 = tm; in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat != 1 || int'(result4) != exp) begin
            check({name, " latency"}, lat, 1);
            check({name, " result"}, int'(result4), exp);
        end else begin
            vectors++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t tbl[6];
        logic [31:0] ra, rb;
        bit rm;
        logic [D1-1:0] held;
        tbl[0] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32};
        tbl[1] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 0};
        tbl[2] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 0};
        tbl[3] = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 32};
        tbl[4] = '{32'h0000_000F, 32'h0000_0000, 1'b0, 4};
        tbl[5] = '{32'h8000_0001, 32'h0000_0000, 1'b1, 30};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", int'(in_ready), 1);
        check("reset out_valid", int'(out_valid), 0);
        check("reset result", int'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run32($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].mode, tbl[i].exp, 33, 33);
        end

        // Randomized against the bit-walking model
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = $urandom; rm = 1'($urandom_range(1));
            if (i % 8 == 0) rb = ra ^ (32'h1 << $urandom_range(31));
            run32($sformatf("rnd%0d", i), ra, rb, rm, ref_count(ra, rb, rm, W1), 33, 33);
        end

        // Backpressure: hold DONE, pulse in_valid, results must stay put
        out_ready = 1'b0;
        @(negedge clk);
        a = 32'hFFFF_0000; b = 32'h0000_0000; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (N1) @(posedge clk);
        #1;
        check("bp out_valid rise", int'(out_valid), 1);
        held = result;
        check("bp result", int'(result), 16);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0); a = 32'h0; b = 32'hFFFF_FFFF;
            @(posedge clk); #1;
            check($sformatf("bp hold%0d", i),
                  {29'd0, out_valid, in_ready, (result == held)}, 3'b101);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp release", {30'd0, in_ready, out_valid}, 2);

        // Reset mid-RUN at idx=2
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = '0; mode = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst async state", {29'd0, in_ready, out_valid, 1'b0}, 3'b100);
        check("rst async result", int'(result), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run32("post-reset", 32'h1, 32'h0, 1'b0, 1, 33, 33);

`ifdef HAMMING_SEQ_THRESH_EN
        run32("thr four", 32'h0000_000F, 32'h0, 1'b0, 4, 5, 5);
        run32("thr five", 32'h0000_001F, 32'h0, 1'b0, 5, 5, 5);
        run32("thr late", 32'h0000_000F, 32'h0, 1'b0, 4, 5, 0);
`endif

        // 4-bit instance: legacy match counter, all 256 pairs, both modes
        run4("w4 legacy", 4'b1010, 4'b1000, 1'b1, 3);
        for (int i = 0; i < 256; i++) begin
            for (int m = 0; m < 2; m++) begin
                run4($sformatf("w4 %0d m%0d", i, m), 4'(i >> 4), 4'(i), 1'(m),
                     ref_count(32'(i >> 4), 32'(i & 15), 1'(m), W2));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
